// File: rtl/chain_mixer_pkg.sv
// Purpose: shared types, default cycle constants and width helpers for the mixer-chain sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package chain_mixer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STAGE,
    INJECT,
    MIX,
    FLUSH,
    DONE
  } state_t;

  localparam int DEF_N_STAGES     = 8;
  localparam int DEF_TW           = 8;
  localparam int DEF_FILL_CYCLES  = 4;
  localparam int DEF_INJ_CYCLES   = 2;
  localparam int DEF_FLUSH_CYCLES = 4;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Width of the stage index; a single-stage chain still gets one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/chain_mixer_seq_if.sv
// Purpose: host/valve-bank bundle of the mixer-chain sequencer.
// Latency: n/a (wires only).
// Backpressure: none; start/abort are level requests, valves are plain levels.
// Ports: master = protocol host side (drives start/abort/mix_time/stage_mask),
//        slave  = sequencer side (drives busy/done/stage_idx/valve_*).
interface chain_mixer_seq_if
  import chain_mixer_pkg::*;
#(
  parameter int N_STAGES = DEF_N_STAGES,
  parameter int TW       = DEF_TW,
  parameter int SW       = idx_w(N_STAGES)
);
  logic                start;
  logic                abort;
  logic [TW-1:0]       mix_time;
  logic [N_STAGES-1:0] stage_mask;
  logic                busy;
  logic                done;
  logic [SW-1:0]       stage_idx;
  logic                valve_in;
  logic [N_STAGES-1:0] valve_k;
  logic                valve_out;

  modport master (
    output start, abort, mix_time, stage_mask,
    input  busy, done, stage_idx, valve_in, valve_k, valve_out
  );

  modport slave (
    input  start, abort, mix_time, stage_mask,
    output busy, done, stage_idx, valve_in, valve_k, valve_out
  );
endinterface

// File: rtl/seq_timer.sv
// Purpose: loadable down-counter timing each valve phase of the sequencer.
// Latency: expire rises load_val cycles after the load edge (count==1 in the last cycle).
// Backpressure: none; load always wins over counting.
// Ports: clk/rst, load + load_val (0 coerced to 1), value = current count, expire = (count==1).
module seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      // A zero-length phase still has to occupy one cycle.
      cnt <= (load_val == '0) ? W'(1) : load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign value  = cnt;
  assign expire = (cnt == W'(1));

endmodule

// File: rtl/chain_mixer_seq.sv
// Purpose: valve sequencer for an N-stage serial mixer chain: fill, per-stage inject+mix, flush, done.
// Latency: outputs registered, valid in the first cycle of each state; run = 1+FILL+N+S*(INJ+max(mix,1))+FLUSH cycles.
// Backpressure: none; start sampled only in IDLE, abort diverts LOAD/STAGE/INJECT/MIX into FLUSH.
// Ports: clk, rst (async, active-high), bus (slave modport: start/abort/mix_time/stage_mask in,
//        busy/done/stage_idx/valve_in/valve_k/valve_out out).
module chain_mixer_seq
  import chain_mixer_pkg::*;
#(
  parameter int N_STAGES     = DEF_N_STAGES,
  parameter int TW           = DEF_TW,
  parameter int FILL_CYCLES  = DEF_FILL_CYCLES,
  parameter int INJ_CYCLES   = DEF_INJ_CYCLES,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input logic               clk,
  input logic               rst,
  chain_mixer_seq_if.slave  bus
);

  localparam int SW = idx_w(N_STAGES);
  // Timer wide enough for mix_time and every fixed phase length.
  localparam int CW = max2(TW, max2(clog2(FILL_CYCLES + 1),
                                    max2(clog2(INJ_CYCLES + 1), clog2(FLUSH_CYCLES + 1))));
  localparam logic [SW-1:0] LAST = SW'(N_STAGES - 1);

  state_t              state, state_nxt;
  logic [SW-1:0]       idx, idx_nxt;
  logic [TW-1:0]       mix_q;
  logic [N_STAGES-1:0] mask_q;

  logic                tmr_load, tmr_exp;
  logic [CW-1:0]       tmr_val;
  logic [CW-1:0]       tmr_value_unused;

  logic                busy_q, done_q, vin_q, vout_q;
  logic [SW-1:0]       idx_q;
  logic [N_STAGES-1:0] vk_q;

  seq_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .value    (tmr_value_unused),
    .expire   (tmr_exp)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE:   if (bus.start) begin
                state_nxt = LOAD;
                idx_nxt   = '0;
              end
      LOAD:   if (tmr_exp) state_nxt = STAGE;
      STAGE:  if (mask_q[idx])      state_nxt = INJECT;
              else if (idx == LAST) state_nxt = FLUSH;
              else                  idx_nxt   = idx + 1'b1;
      INJECT: if (tmr_exp) state_nxt = MIX;
      MIX:    if (tmr_exp) begin
                if (idx == LAST) state_nxt = FLUSH;
                else begin
                  state_nxt = STAGE;
                  idx_nxt   = idx + 1'b1;
                end
              end
      FLUSH:  if (tmr_exp) state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Abort only matters while liquid is being staged; IDLE is handled above so start wins.
    if (bus.abort && (state inside {LOAD, STAGE, INJECT, MIX})) state_nxt = FLUSH;

    // Timed states are never re-entered from themselves, so a state change marks entry.
    tmr_load = (state_nxt != state) && (state_nxt inside {LOAD, INJECT, MIX, FLUSH});
    case (state_nxt)
      LOAD:    tmr_val = CW'(FILL_CYCLES);
      INJECT:  tmr_val = CW'(INJ_CYCLES);
      MIX:     tmr_val = CW'(mix_q);
      FLUSH:   tmr_val = CW'(FLUSH_CYCLES);
      default: tmr_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      mix_q  <= '0;
      mask_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      vin_q  <= 1'b0;
      vout_q <= 1'b0;
      idx_q  <= '0;
      vk_q   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (state == IDLE && bus.start) begin
        mix_q  <= bus.mix_time;
        mask_q <= bus.stage_mask;
      end
      // Outputs decode the next state so they line up with the first cycle of that state.
      busy_q <= (state_nxt != IDLE);
      done_q <= (state_nxt == DONE);
      vin_q  <= (state_nxt == LOAD);
      vout_q <= (state_nxt == FLUSH);
      vk_q   <= (state_nxt == INJECT) ? (N_STAGES'(1) << idx_nxt) : '0;
      idx_q  <= (state_nxt inside {STAGE, INJECT, MIX}) ? idx_nxt : '0;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.valve_in  = vin_q;
  assign bus.valve_out = vout_q;
  assign bus.valve_k   = vk_q;
  assign bus.stage_idx = idx_q;

endmodule

// File: tb/tb_chain_mixer_seq.sv
// Purpose: directed and randomised checks of the mixer-chain sequencer timeline.
// Latency: cycle c = c-th cycle after the edge that samples start; outputs sampled on negedge.
// Backpressure: n/a.
module tb_chain_mixer_seq;

  localparam int MAXC = 400;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Packed observation per cycle: {busy, done, valve_in, valve_out, stage_idx[2:0], valve_k[7:0]}
  logic [14:0] t_obs [0:MAXC+1];
  int done_cyc, done_cnt, multi_valve;

  chain_mixer_seq_if #(.N_STAGES(8), .TW(8)) bus ();

  chain_mixer_seq #(
    .N_STAGES(8), .TW(8), .FILL_CYCLES(4), .INJ_CYCLES(2), .FLUSH_CYCLES(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] pk(input logic b, input logic d, input logic vi,
                                     input logic vo, input logic [2:0] ix, input logic [7:0] k);
    return {b, d, vi, vo, ix, k};
  endfunction

  function automatic logic [14:0] cur_obs();
    return pk(bus.busy, bus.done, bus.valve_in, bus.valve_out, bus.stage_idx, bus.valve_k);
  endfunction

  // Request a run; start is sampled at the posedge inside this task (edge 0).
  task automatic launch(input logic [7:0] mt, input logic [7:0] mk, input logic ab);
    @(negedge clk);
    bus.mix_time   = mt;
    bus.stage_mask = mk;
    bus.start      = 1'b1;
    bus.abort      = ab;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  // Record one run into t_obs until one cycle after done, bounded by MAXC.
  task automatic capture(input int abort_at);
    done_cyc    = 0;
    done_cnt    = 0;
    multi_valve = 0;
    for (int i = 0; i <= MAXC + 1; i++) t_obs[i] = '0;
    for (int c = 1; c <= MAXC; c++) begin
      @(negedge clk);
      t_obs[c] = cur_obs();
      if (bus.done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if ((int'(bus.valve_in) + int'(bus.valve_out) + $countones(bus.valve_k)) > 1) multi_valve++;
      bus.abort = (c == abort_at);
      if (done_cyc != 0 && c >= done_cyc + 1) break;
    end
    bus.abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (cur_obs() !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h", cur_obs(), 15'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cur_obs() !== 15'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %h expected %h", cur_obs(), 15'd0);
    end
  endtask

  // mix_time=3, all stages: LOAD 1-4, stage g in 5+6g..10+6g (inject at +1,+2), FLUSH 53-56, done 57.
  task automatic test_full_run();
    logic [14:0] e;
    int g, ph;
    launch(8'd3, 8'hFF, 1'b0);
    capture(0);
    for (int c = 1; c <= 58; c++) begin
      if (c <= 4) e = pk(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00);
      else if (c <= 52) begin
        g  = (c - 5) / 6;
        ph = (c - 5) % 6;
        e  = pk(1'b1, 1'b0, 1'b0, 1'b0, 3'(g), (ph == 1 || ph == 2) ? 8'(1 << g) : 8'h00);
      end
      else if (c <= 56) e = pk(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00);
      else if (c == 57) e = pk(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
      else e = 15'd0;
      n_checks++;
      if (t_obs[c] !== e) begin
        n_fail++;
        $display("FAIL full_run cycle %0d: got %h expected %h", c, t_obs[c], e);
      end
    end
    n_checks++;
    if (done_cyc !== 57) begin
      n_fail++;
      $display("FAIL full_run_done_cycle: got %0d expected 57", done_cyc);
    end
  endtask

  // No stages selected: STAGE 5-12 (idx 0..7), FLUSH 13-16, done 17.
  task automatic test_empty_mask();
    logic [14:0] e;
    launch(8'd3, 8'h00, 1'b0);
    capture(0);
    for (int c = 1; c <= 18; c++) begin
      if (c <= 4)       e = pk(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00);
      else if (c <= 12) e = pk(1'b1, 1'b0, 1'b0, 1'b0, 3'(c - 5), 8'h00);
      else if (c <= 16) e = pk(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00);
      else if (c == 17) e = pk(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
      else              e = 15'd0;
      n_checks++;
      if (t_obs[c] !== e) begin
        n_fail++;
        $display("FAIL empty_mask cycle %0d: got %h expected %h", c, t_obs[c], e);
      end
    end
  endtask

  // mask 81, mix_time 0 (one MIX cycle): k0 on 6-7, k7 on 16-17, FLUSH 19-22, done 23.
  task automatic test_sparse_mask();
    logic [14:0] e;
    launch(8'd0, 8'h81, 1'b0);
    capture(0);
    for (int c = 1; c <= 24; c++) begin
      if (c <= 4)                e = pk(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00);
      else if (c == 6 || c == 7) e = pk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h01);
      else if (c <= 8)           e = pk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
      else if (c <= 14)          e = pk(1'b1, 1'b0, 1'b0, 1'b0, 3'(c - 8), 8'h00);
      else if (c == 16 || c == 17) e = pk(1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 8'h80);
      else if (c <= 18)          e = pk(1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 8'h00);
      else if (c <= 22)          e = pk(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00);
      else if (c == 23)          e = pk(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
      else                       e = 15'd0;
      n_checks++;
      if (t_obs[c] !== e) begin
        n_fail++;
        $display("FAIL sparse_mask cycle %0d: got %h expected %h", c, t_obs[c], e);
      end
    end
  endtask

  // Abort sampled at the end of cycle 26 (first MIX cycle of stage 3): FLUSH 27-30, done 31.
  task automatic test_abort_mix();
    logic [14:0] e;
    int g, ph;
    launch(8'd3, 8'hFF, 1'b0);
    capture(26);
    for (int c = 1; c <= 32; c++) begin
      if (c <= 4) e = pk(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00);
      else if (c <= 26) begin
        g  = (c - 5) / 6;
        ph = (c - 5) % 6;
        e  = pk(1'b1, 1'b0, 1'b0, 1'b0, 3'(g), (ph == 1 || ph == 2) ? 8'(1 << g) : 8'h00);
      end
      else if (c <= 30) e = pk(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00);
      else if (c == 31) e = pk(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
      else              e = 15'd0;
      n_checks++;
      if (t_obs[c] !== e) begin
        n_fail++;
        $display("FAIL abort_mix cycle %0d: got %h expected %h", c, t_obs[c], e);
      end
    end
  endtask

  task automatic test_reset_mid_inject();
    launch(8'd3, 8'hFF, 1'b0);
    repeat (6) @(negedge clk);
    n_checks++;
    if (bus.valve_k !== 8'h01) begin
      n_fail++;
      $display("FAIL inject_before_rst: got %h expected %h", bus.valve_k, 8'h01);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (cur_obs() !== 15'd0) begin
      n_fail++;
      $display("FAIL async_rst_outputs: got %h expected %h", cur_obs(), 15'd0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // mask 02, mix 1: STAGE0 5, STAGE1 6, INJECT 7-8, MIX 9, FLUSH 16-19, done 20.
    launch(8'd1, 8'h02, 1'b0);
    capture(0);
    n_checks++;
    if (t_obs[1] !== pk(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00)) begin
      n_fail++;
      $display("FAIL restart_load: got %h expected %h", t_obs[1], pk(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00));
    end
    n_checks++;
    if (t_obs[7] !== pk(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 8'h02)) begin
      n_fail++;
      $display("FAIL restart_inject: got %h expected %h", t_obs[7], pk(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 8'h02));
    end
    n_checks++;
    if (done_cyc !== 20) begin
      n_fail++;
      $display("FAIL restart_done_cycle: got %0d expected 20", done_cyc);
    end
  endtask

  // start presented in the DONE cycle must not launch another run.
  task automatic test_done_start();
    int seen;
    seen = 0;
    launch(8'd0, 8'h00, 1'b0);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = c;
        break;
      end
    end
    n_checks++;
    if (seen !== 17) begin
      n_fail++;
      $display("FAIL done_start_done_cycle: got %0d expected 17", seen);
    end
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_in_done_ignored: busy got %b expected 0", bus.busy);
    end
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_in_done_still_idle: busy got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_abort_ignored();
    bus.abort = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_in_idle cycle %0d: busy got %b expected 0", c, bus.busy);
      end
    end
    bus.abort = 1'b0;
    // Abort during FLUSH (cycle 14) leaves the flush length untouched.
    launch(8'd3, 8'h00, 1'b0);
    capture(14);
    n_checks++;
    if (done_cyc !== 17) begin
      n_fail++;
      $display("FAIL abort_in_flush_done_cycle: got %0d expected 17", done_cyc);
    end
    n_checks++;
    if (t_obs[16] !== pk(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00)) begin
      n_fail++;
      $display("FAIL abort_in_flush_valve: got %h expected %h", t_obs[16], pk(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00));
    end
  endtask

  task automatic test_start_abort();
    launch(8'd3, 8'h00, 1'b1);
    capture(0);
    n_checks++;
    if (t_obs[1] !== pk(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00)) begin
      n_fail++;
      $display("FAIL start_beats_abort: got %h expected %h", t_obs[1], pk(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00));
    end
    n_checks++;
    if (done_cyc !== 17) begin
      n_fail++;
      $display("FAIL start_beats_abort_done_cycle: got %0d expected 17", done_cyc);
    end
  endtask

  task automatic test_random();
    logic [7:0] mt, mk;
    int exp_done, m_eff;
    for (int r = 0; r < 1000; r++) begin
      mt = 8'($urandom_range(0, 7));
      mk = 8'($urandom_range(0, 255));
      m_eff = (mt == 8'd0) ? 1 : int'(mt);
      exp_done = 1 + 4 + 8 + $countones(mk) * (2 + m_eff) + 4;
      launch(mt, mk, 1'b0);
      capture(0);
      n_checks++;
      if (done_cyc !== exp_done) begin
        n_fail++;
        $display("FAIL random_done_cycle run %0d mt=%0d mask=%h: got %0d expected %0d", r, mt, mk, done_cyc, exp_done);
      end
      n_checks++;
      if (done_cnt !== 1) begin
        n_fail++;
        $display("FAIL random_done_width run %0d: got %0d expected 1", r, done_cnt);
      end
      n_checks++;
      if (multi_valve !== 0) begin
        n_fail++;
        $display("FAIL random_valve_exclusive run %0d: got %0d overlapping cycles expected 0", r, multi_valve);
      end
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.mix_time   = 8'd0;
    bus.stage_mask = 8'h00;
    test_reset();
    test_full_run();
    test_empty_mask();
    test_sparse_mask();
    test_abort_mix();
    test_reset_mid_inject();
    test_done_start();
    test_abort_ignored();
    test_start_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
